// File: rtl/dsig_delta_arbiter.sv
// Round-robin arbiter feeding a shared 3-stage pipeline that computes
// delta = e * a*(1-a) in signed fixed point, tagged with the requester index.
module dsig_delta_arbiter #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WIDTH-1:0]  req_a,
    input  logic [NREQ*WIDTH-1:0]  req_err,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_delta,
    output logic [IDW-1:0]         out_id,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int PW = 2 * WIDTH + 1;
    localparam logic signed [WIDTH:0] ONE_X = {{(WIDTH - FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] x);
        if ((&x[PW-1:WIDTH-1]) || !(|x[PW-1:WIDTH-1]))
            sat = x[WIDTH-1:0];
        else if (x[PW-1])
            sat = {1'b1, {(WIDTH - 1){1'b0}}};
        else
            sat = {1'b0, {(WIDTH - 1){1'b1}}};
    endfunction

    logic [IDW-1:0]          ptr;
    logic                    stall;
    logic                    accept;
    logic [NREQ-1:0]         gnt;
    logic [IDW-1:0]          gnt_id;
    logic [IDW-1:0]          next_ptr;
    logic [WIDTH-1:0]        gnt_a;
    logic [WIDTH-1:0]        gnt_e;
    logic                    found;
    int unsigned             idx;

    logic                    s1_v;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_e;
    logic [IDW-1:0]          s1_id;

    logic                    s2_v;
    logic signed [WIDTH-1:0] s2_d;
    logic signed [WIDTH-1:0] s2_e;
    logic [IDW-1:0]          s2_id;

    logic signed [WIDTH:0]   one_m_a;
    logic signed [PW-1:0]    p1;
    logic signed [PW-1:0]    p2;
    logic signed [WIDTH-1:0] d_next;
    logic signed [WIDTH-1:0] delta_next;

    assign stall = out_valid & ~out_ready;
    assign busy  = s1_v | s2_v | out_valid;

    // Search starts at ptr and wraps; first valid requester wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        gnt_a  = '0;
        gnt_e  = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IDW'(idx);
                gnt_a       = req_a[idx*WIDTH +: WIDTH];
                gnt_e       = req_err[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = (rst || stall) ? '0 : gnt;
    assign accept    = |(req_valid & req_ready);
    assign next_ptr  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    always_comb begin
        one_m_a    = ONE_X - {s1_a[WIDTH-1], s1_a};
        p1         = {{(WIDTH + 1){s1_a[WIDTH-1]}}, s1_a} * {{WIDTH{one_m_a[WIDTH]}}, one_m_a};
        d_next     = sat(p1 >>> FRAC);
        p2         = {{(WIDTH + 1){s2_d[WIDTH-1]}}, s2_d} * {{(WIDTH + 1){s2_e[WIDTH-1]}}, s2_e};
        delta_next = sat(p2 >>> FRAC);
    end

    // A stall freezes every stage, so the output registers hold until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s1_e      <= '0;
            s1_id     <= '0;
            s2_v      <= 1'b0;
            s2_d      <= '0;
            s2_e      <= '0;
            s2_id     <= '0;
            out_valid <= 1'b0;
            out_delta <= '0;
            out_id    <= '0;
        end else begin
            if (accept)
                ptr <= next_ptr;
            if (!stall) begin
                s1_v <= accept;
                if (accept) begin
                    s1_a  <= gnt_a;
                    s1_e  <= gnt_e;
                    s1_id <= gnt_id;
                end
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_d  <= d_next;
                    s2_e  <= s1_e;
                    s2_id <= s1_id;
                end
                out_valid <= s2_v;
                if (s2_v) begin
                    out_delta <= delta_next;
                    out_id    <= s2_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsig_delta_arbiter.sv
// Randomised and directed bench for dsig_delta_arbiter against a
// transaction-level queue model with 64-bit reference arithmetic.
module tb_dsig_delta_arbiter;

    localparam int W = 32;
    localparam int F = 24;
    localparam int N = 4;
    localparam longint ONE = 64'sd1 <<< F;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_err;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_delta;
    logic [1:0]     out_id;
    logic           out_ready;
    logic           busy;

    always #5 clk = ~clk;

    dsig_delta_arbiter #(.WIDTH(W), .FRAC(F), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_err(req_err),
        .req_ready(req_ready), .out_valid(out_valid), .out_delta(out_delta),
        .out_id(out_id), .out_ready(out_ready), .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] e;
        int          stage;
    } ent_t;

    ent_t q[$];
    int   mptr = 0;
    int   errors = 0;
    int   checks = 0;

    logic        st_rst;
    logic [3:0]  st_v;
    logic        st_ordy;
    logic [31:0] st_a[N];
    logic [31:0] st_e[N];

    logic        obs_ov, obs_busy;
    logic [31:0] obs_delta;
    logic [1:0]  obs_id;
    logic [3:0]  obs_rdy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat32(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic logic [31:0] ref_delta(input logic [31:0] a, input logic [31:0] e);
        longint sa, se, d, r;
        sa = $signed(a);
        se = $signed(e);
        d  = sat32((sa * (ONE - sa)) >>> F);
        r  = sat32((d * se) >>> F);
        return r[31:0];
    endfunction

    function automatic logic [31:0] rand_a();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 32'h0100_0000);
            1: return $urandom;
            2: return 32'h0100_0000 - $urandom_range(0, 255);
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    function automatic logic [31:0] rand_e();
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: return $urandom_range(0, 32'h0400_0000) - 32'h0200_0000;
            default: return $urandom_range(0, 32'h0100_0000);
        endcase
    endfunction

    // One clock: drive at negedge, check combinational/registered outputs, then step the model.
    task automatic cycle();
        logic [3:0] erdy;
        logic       eov, stall;
        int         gi;
        ent_t       ne;
        @(negedge clk);
        rst       = st_rst;
        req_valid = st_v;
        out_ready = st_ordy;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W]   = st_a[i];
            req_err[i*W +: W] = st_e[i];
        end
        #1;
        eov   = (q.size() > 0) && (q[0].stage == 3);
        stall = eov && !st_ordy;
        erdy  = '0;
        gi    = -1;
        if (!st_rst && !stall) begin
            for (int k = 0; k < N; k++) begin
                if (st_v[(mptr + k) % N]) begin
                    gi = (mptr + k) % N;
                    break;
                end
            end
        end
        if (gi >= 0) erdy[gi] = 1'b1;
        check_val("req_ready", 64'(req_ready), 64'(erdy));
        check_val("out_valid", 64'(out_valid), 64'(eov));
        check_val("busy", 64'(busy), 64'(q.size() > 0));
        if (eov) begin
            check_val("out_delta", 64'(out_delta), 64'(ref_delta(q[0].a, q[0].e)));
            check_val("out_id", 64'(out_id), 64'(q[0].id));
        end
        obs_ov    = out_valid;
        obs_busy  = busy;
        obs_delta = out_delta;
        obs_id    = out_id;
        obs_rdy   = req_ready;
        if (st_rst) begin
            q.delete();
            mptr = 0;
        end else if (!stall) begin
            if (eov && st_ordy) q.delete(0);
            foreach (q[j]) q[j].stage++;
            if (gi >= 0) begin
                ne.id = gi; ne.a = st_a[gi]; ne.e = st_e[gi]; ne.stage = 1;
                q.push_back(ne);
                mptr = (gi + 1) % N;
            end
        end
    endtask

    task automatic idle(input int n);
        st_v = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic randomize_data();
        for (int i = 0; i < N; i++) begin
            st_a[i] = rand_a();
            st_e[i] = rand_e();
        end
    endtask

    logic [31:0] held_d;
    logic [1:0]  held_id;

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_err = '0; out_ready = 1'b1;
        st_rst = 1'b0; st_v = '0; st_ordy = 1'b1;
        for (int i = 0; i < N; i++) begin st_a[i] = '0; st_e[i] = '0; end
        repeat (2) @(posedge clk);

        // Reset state
        cycle();
        check_val("rst_delta", 64'(obs_delta), 64'h0);
        check_val("rst_id", 64'(obs_id), 64'h0);

        // Basic delta, 3-cycle latency
        st_v = 4'b0001; st_a[0] = 32'h0080_0000; st_e[0] = 32'h0100_0000;
        cycle();
        st_v = '0;
        cycle(); cycle();
        check_val("lat_early", 64'(obs_ov), 64'h0);
        cycle();
        check_val("basic_valid", 64'(obs_ov), 64'h1);
        check_val("basic_delta", 64'(obs_delta), 64'h0040_0000);
        check_val("basic_id", 64'(obs_id), 64'h0);

        // Negative error, then zero activation
        st_v = 4'b0001; st_a[0] = 32'h0080_0000; st_e[0] = 32'hFE00_0000;
        cycle();
        st_a[0] = 32'h0; st_e[0] = 32'h0500_0000;
        cycle();
        st_v = '0;
        cycle(); cycle();
        check_val("neg_delta", 64'(obs_delta), 64'hFF80_0000);
        cycle();
        check_val("zero_valid", 64'(obs_ov), 64'h1);
        check_val("zero_delta", 64'(obs_delta), 64'h0);

        // Saturation to most-negative
        st_v = 4'b0001; st_a[0] = 32'h0400_0000; st_e[0] = 32'h7F00_0000;
        cycle();
        idle(3);
        check_val("sat_delta", 64'(obs_delta), 64'h8000_0000);

        // Round-robin from ptr=0
        st_rst = 1'b1; cycle(); st_rst = 1'b0;
        for (int k = 0; k < 11; k++) begin
            st_v = (k < 8) ? 4'b1111 : 4'b0000;
            randomize_data();
            cycle();
            if (k < 8) check_val("rr_grant", 64'(obs_rdy), 64'(4'b0001 << (k % 4)));
            if (k >= 3) check_val("rr_id", 64'(obs_id), 64'((k - 3) % 4));
        end

        // Backpressure
        st_v = 4'b1111;
        for (int k = 0; k < 4; k++) begin randomize_data(); cycle(); end
        st_ordy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            randomize_data();
            cycle();
            if (k == 0) begin held_d = obs_delta; held_id = obs_id; end
            check_val("bp_ready", 64'(obs_rdy), 64'h0);
            check_val("bp_hold_d", 64'(obs_delta), 64'(held_d));
            check_val("bp_hold_id", 64'(obs_id), 64'(held_id));
        end
        st_ordy = 1'b1;
        idle(8);

        // Reset mid-flight
        st_v = 4'b1111;
        for (int k = 0; k < 3; k++) begin randomize_data(); cycle(); end
        st_v = '0; st_rst = 1'b1;
        cycle();
        st_rst = 1'b0;
        cycle();
        check_val("mid_rst_valid", 64'(obs_ov), 64'h0);
        check_val("mid_rst_busy", 64'(obs_busy), 64'h0);
        check_val("mid_rst_ptr", 64'(dut.ptr), 64'h0);
        st_v = 4'b0100; st_a[2] = 32'h0040_0000; st_e[2] = 32'hFF00_0000;
        cycle();
        idle(3);
        check_val("post_rst_id", 64'(obs_id), 64'h2);
        check_val("post_rst_delta", 64'(obs_delta), 64'(ref_delta(32'h0040_0000, 32'hFF00_0000)));

        // ptr now at 3: lone req0 wraps ptr to 1
        st_v = 4'b0001; cycle();
        check_val("wrap_grant", 64'(obs_rdy), 64'h1);
        st_v = 4'b0011; cycle();
        check_val("wrap_next", 64'(obs_rdy), 64'h2);

        // Single requester held valid
        st_v = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            randomize_data();
            cycle();
            check_val("single_grant", 64'(obs_rdy), 64'h8);
        end
        idle(4);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            st_rst  = ($urandom_range(0, 99) == 0);
            st_v    = 4'($urandom);
            st_ordy = ($urandom_range(0, 3) != 0);
            randomize_data();
            cycle();
        end
        st_rst = 1'b0; st_ordy = 1'b1;
        idle(6);
        check_val("drain_empty", 64'(obs_busy), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
